branch_resolver: RTL
====================

Name: branch_resolver

Overview:
- Counterpart of the 2-bit saturating branch predictor. It issues `request` to the predictor and captures `prediction` one cycle later.
- Holds in-flight predictions in program order, compares each against the actual outcome from execute, and drives the predictor's `result`/`taken` update port.
- Raises a mispredict flush to fetch.
- Sits between fetch, execute and the predictor.

Parameters:
- DEPTH, 4, maximum in-flight predicted branches (power of 2, ≥2).
- CNT_W, 8, width of mispredict statistics counter.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- br_valid  in  1  fetch presents a new branch this cycle.
- br_ready  out  1  resolver can accept a branch.
- pred_request  out  1  to predictor `request`.
- pred_in  in  1  from predictor `prediction`.
- fetch_pred_valid  out  1  prediction for the oldest-issued pending branch is available this cycle.
- fetch_pred_taken  out  1  that prediction.
- resolve_valid  in  1  execute resolves the oldest in-flight branch.
- resolve_taken  in  1  actual outcome.
- upd_result  out  1  to predictor `result`.
- upd_taken  out  1  to predictor `taken`.
- mispredict  out  1  one-cycle flush pulse to fetch.
- err_underflow  out  1  one-cycle pulse: resolve with no captured entry.
- mispredict_cnt  out  CNT_W  saturating mispredict count.

Behaviour:
- **Reset** (rst_n=0 at posedge): FIFO empty, pointers 0, pending=0, state=RUN. All registered outputs 0, mispredict_cnt=0.
- **Issue:**
  - br_ready = (state==RUN) && (occupancy + pending < DEPTH); combinational.
  - pred_request = br_valid && br_ready; combinational.
  - On accept, pending<=1.
- **Capture:** the cycle after an accept (pending=1):
  - fetch_pred_valid=1 and fetch_pred_taken=pred_in (combinational from pred_in).
  - pred_in is pushed into the FIFO at the posedge; pending clears unless a new accept occurs the same cycle.
- **Back-to-back accepts** are allowed; pending then stays 1.
- **Resolve** (resolve_valid=1, state==RUN, occupancy≥1):
  - Pop the head; register upd_result=1 and upd_taken=resolve_taken for exactly one cycle (latency 1).
  - If resolve_taken != head prediction: register mispredict=1, increment mispredict_cnt (saturate at all-ones), and state<=FLUSH.
- **Underflow:** resolve_valid=1 with occupancy=0 (including when only pending=1):
  - err_underflow pulses next cycle.
  - No pop, no update, no state change.
- **Simultaneous push and pop:** occupancy unchanged, pointers both advance, wrap modulo DEPTH.
- **Full:** br_ready=0; a pop in the same cycle does not raise br_ready until the next cycle.
- **Mispredict flush** (entering FLUSH at the mispredicting posedge):
  - FIFO cleared (pointers reset, occupancy 0).
  - pending cleared; the outstanding pred_in is discarded, and fetch_pred_valid is forced 0 in the FLUSH cycle.
  - A push coinciding with the mispredicting pop is discarded.
- **FLUSH lasts exactly 1 cycle:**
  - br_ready=0; br_valid and resolve_valid are ignored (no error pulse).
  - Next state is RUN.
- **FSM:** RUN → FLUSH on mispredict; FLUSH → RUN unconditionally; any state → RUN on reset.
- **Reset mid-operation:** discards all in-flight entries. Any predictor update registered the same cycle is suppressed, so upd_result=0 in the next cycle.

Decomposition:
- Shared package holds:
  - state enum {RUN, FLUSH};
  - a helper for the DEPTH-derived pointer width, `clog2(DEPTH)`.
- One natural sub-module: `pred_fifo`, a 1-bit-wide, DEPTH-entry synchronous FIFO with push, pop, clear, occupancy, and synchronous active-low reset.
- FSM, pending flag, update register and counter stay in `branch_resolver`.

Test Plan:
- **Reset, then single branch:**
  - Stimulus: br_valid=1 for 1 cycle; pred_in=1 next cycle.
  - Required: pred_request=1 in cycle 0; fetch_pred_valid=1 and fetch_pred_taken=1 in cycle 1; occupancy=1.
  - Then resolve_taken=1 → upd_result=1 and upd_taken=1 one cycle later; mispredict=0.
- **Fill to DEPTH=4:**
  - Stimulus: 4 back-to-back br_valid.
  - Required: br_ready=0 after the 4th accept.
  - Resolve 1 with br_valid held → no new accept in the pop cycle, accept in the following cycle.
- **Mispredict:**
  - Stimulus: 3 entries, predictions {1,1,0}; resolve_taken=0 on the head.
  - Required, next cycle: upd_result=1, upd_taken=0, mispredict=1, mispredict_cnt=1.
  - Required, FLUSH cycle: br_ready=0; occupancy=0 afterwards.
- **Mispredict with pending:**
  - Stimulus: accept a branch in the same cycle as the mispredicting resolve.
  - Required: its prediction is discarded; fetch_pred_valid=0; occupancy=0 after FLUSH.
- **Underflow:**
  - Stimulus: resolve_valid=1 with an empty FIFO.
  - Required: err_underflow=1 for 1 cycle; upd_result=0; state stays RUN.
- **Counter saturation and mid-flight reset:**
  - Stimulus: CNT_W=2, force 5 mispredicts.
  - Required: mispredict_cnt=3.
  - Then rst_n=0 with 2 entries in flight → all outputs 0 and occupancy 0 next cycle.

Source files
------------

// File: rtl/branch_resolver_pkg.sv
// Shared types for the branch resolver: FSM states and pointer-width helper.
package branch_resolver_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/pred_fifo.sv
// 1-bit, DEPTH-entry in-order prediction store; push/pop take effect at the clock edge.
// Head is combinational; clear wins over push/pop; push when full and pop when empty are dropped.
module pred_fifo
    import branch_resolver_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = ptr_w(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        push_data,
    input  logic        pop,
    input  logic        clear,
    output logic        head,
    output logic [PW:0] occupancy
);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (occupancy != (PW+1)'(DEPTH));
    assign do_pop  = pop && (occupancy != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Issues predictor requests, holds predictions in program order and resolves them against execute.
// Update/mispredict/underflow outputs are registered (latency 1); br_ready drops when in-flight reaches DEPTH or during FLUSH.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    output logic             br_ready,
    output logic             pred_request,
    input  logic             pred_in,
    output logic             fetch_pred_valid,
    output logic             fetch_pred_taken,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    output logic             upd_result,
    output logic             upd_taken,
    output logic             mispredict,
    output logic             err_underflow,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int PW = ptr_w(DEPTH);

    state_t        state;
    state_t        state_nxt;
    logic          pending;
    logic [PW:0]   occupancy;
    logic [PW+1:0] inflight;
    logic          head;
    logic          accept;
    logic          capture;
    logic          resolve_ok;
    logic          mis_now;
    logic          underflow;

    // Branches already captured plus the one whose prediction arrives this cycle.
    assign inflight = {1'b0, occupancy} + {{(PW+1){1'b0}}, pending};

    always_comb begin
        br_ready         = (state == RUN) && (inflight < (PW+2)'(DEPTH));
        accept           = br_valid && br_ready;
        pred_request     = accept;
        capture          = pending && (state == RUN);
        fetch_pred_valid = capture;
        fetch_pred_taken = pred_in;
        resolve_ok       = resolve_valid && (state == RUN) && (occupancy != '0);
        underflow        = resolve_valid && (state == RUN) && (occupancy == '0);
        mis_now          = resolve_ok && (resolve_taken != head);
        state_nxt        = RUN;
        if (state == RUN && mis_now) begin
            state_nxt = FLUSH;
        end
    end

    pred_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (capture),
        .push_data (pred_in),
        .pop       (resolve_ok),
        .clear     (mis_now),
        .head      (head),
        .occupancy (occupancy)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= RUN;
            pending        <= 1'b0;
            upd_result     <= 1'b0;
            upd_taken      <= 1'b0;
            mispredict     <= 1'b0;
            err_underflow  <= 1'b0;
            mispredict_cnt <= '0;
        end else begin
            state         <= state_nxt;
            // A flush drops the prediction still owed to a branch accepted this cycle.
            pending       <= accept && !mis_now;
            upd_result    <= resolve_ok;
            upd_taken     <= resolve_ok && resolve_taken;
            mispredict    <= mis_now;
            err_underflow <= underflow;
            if (mis_now && (mispredict_cnt != '1)) begin
                mispredict_cnt <= mispredict_cnt + 1'b1;
            end
        end
    end

endmodule
